pc_gen: RTL

- Parametrised program-counter generator for the IF stage; successor to the fixed single-width PC register.
- Configurable address width, step size and reset/trap vectors, with an IMEM ready handshake.
- Redirects (trap, EX branch, ID jump) that arrive while fetch is blocked are captured in a pending slot, so none is lost.
- Feeds IMEM address and IF/ID pipeline register; emits redirect pulse for flush logic.

---
 rtl/pc_gen_if.sv | 23 ++
 rtl/pc_gen.sv | 53 +++++
 2 files changed

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-redirect request bus and PC outputs shared by the IF stage and pc_gen.
interface pc_gen_if #(parameter int ADDR_WIDTH = 32);
  logic                  pc_stall;
  logic                  fetch_ready;
  logic                  trap;
  logic                  ex_pc_branch;
  logic [ADDR_WIDTH-1:0] ex_pc_branch_dest;
  logic                  id_jump;
  logic [ADDR_WIDTH-1:0] id_pc_dest;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic                  fetch_valid;
  logic                  pc_redirect;
  logic                  redirect_pending;
  logic                  target_misaligned;
  modport master (
    output pc_stall, fetch_ready, trap, ex_pc_branch, ex_pc_branch_dest, id_jump, id_pc_dest,
    input  pc_out, fetch_valid, pc_redirect, redirect_pending, target_misaligned
  );
  modport slave (
    input  pc_stall, fetch_ready, trap, ex_pc_branch, ex_pc_branch_dest, id_jump, id_pc_dest,
    output pc_out, fetch_valid, pc_redirect, redirect_pending, target_misaligned
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: parametrised IF-stage program counter with prioritised redirects and a pending-redirect slot.
module pc_gen #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    PC_STEP      = 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = ADDR_WIDTH'(32'h0000_0040)
) (
  input logic   clk,
  input logic   rst,
  pc_gen_if.slave bus
);
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  addr_t       pc, slot_tgt, live_tgt, sel, aligned;
  logic [1:0]  slot_code, live_code;
  logic        fv, redir, mis;
  logic        tadv, adv, trap_go, slot_trap_go, live_go, slot_go, load, capture, mis_nxt;
  assign tadv         = fv & bus.fetch_ready;
  assign adv          = tadv & ~bus.pc_stall;
  assign live_code    = bus.trap ? 2'd3 : bus.ex_pc_branch ? 2'd2 : bus.id_jump ? 2'd1 : 2'd0;
  assign live_tgt     = bus.trap ? TRAP_VECTOR : bus.ex_pc_branch ? bus.ex_pc_branch_dest : bus.id_pc_dest;
  assign trap_go      = bus.trap & tadv;
  assign slot_trap_go = (slot_code == 2'd3) & tadv;
  assign live_go      = (live_code != 2'd0) & adv;
  assign slot_go      = (slot_code != 2'd0) & adv;
  assign load         = trap_go | slot_trap_go | live_go | slot_go;
  // A live EX/ID request is younger than whatever sits in the slot, so it wins over slot codes 1/2.
  assign sel          = trap_go ? TRAP_VECTOR : slot_trap_go ? slot_tgt : live_go ? live_tgt : slot_tgt;
  assign aligned      = (PC_STEP == 4) ? (sel & ~addr_t'(3)) : sel;
  assign mis_nxt      = load & (PC_STEP == 4) & (sel[1:0] != 2'b00);
  assign capture      = ~load & (live_code != 2'd0) & (live_code >= slot_code);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_VECTOR;
      fv        <= 1'b0;
      redir     <= 1'b0;
      mis       <= 1'b0;
      slot_code <= 2'd0;
      slot_tgt  <= '0;
    end else begin
      fv        <= 1'b1;
      redir     <= load;
      mis       <= mis_nxt;
      pc        <= load ? aligned : adv ? pc + addr_t'(PC_STEP) : pc;
      slot_code <= load ? 2'd0 : capture ? live_code : slot_code;
      slot_tgt  <= load ? '0 : capture ? live_tgt : slot_tgt;
    end
  end
  assign bus.pc_out            = pc;
  assign bus.fetch_valid       = fv;
  assign bus.pc_redirect       = redir;
  assign bus.redirect_pending  = slot_code != 2'd0;
  assign bus.target_misaligned = mis;
endmodule
